// File: rtl/eth_link_ctrl.sv
// Per-lane QSFP link bring-up and supervision controller.
// Sequences GT reset, reset-done and PCS lock; filters lock loss and counts retries.
module eth_link_ctrl #(
  parameter int LANES          = 4,
  parameter int RESET_CYCLES   = 1024,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_CYCLES  = 1024
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clock_ok,
  input  logic [LANES-1:0]   lane_enable,
  input  logic               status_clear,
  input  logic [LANES-1:0]   gt_tx_done,
  input  logic [LANES-1:0]   gt_rx_done,
  input  logic [LANES-1:0]   rx_block_lock,
  input  logic [LANES-1:0]   rx_high_ber,
  output logic [LANES-1:0]   gt_reset_all,
  output logic [LANES-1:0]   lane_up,
  output logic [2*LANES-1:0] lane_state,
  output logic [8*LANES-1:0] retry_count,
  output logic [8*LANES-1:0] down_count
);

  localparam int TMAX = (RESET_CYCLES > TIMEOUT_CYCLES) ?
                        RESET_CYCLES : TIMEOUT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int FW = $clog2(FILTER_CYCLES + 1);

  localparam logic [TW-1:0] T_RST  = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] T_TO   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_WAIT_LOCK = 2'd2,
    ST_UP        = 2'd3
  } state_t;

  logic [4*LANES-1:0] meta_q;
  logic [4*LANES-1:0] sync_q;
  logic [LANES-1:0]   done;
  logic [LANES-1:0]   good;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {gt_tx_done, gt_rx_done,
                 rx_block_lock, rx_high_ber};
      sync_q <= meta_q;
    end
  end

  assign done = sync_q[4*LANES-1:3*LANES]
              & sync_q[3*LANES-1:2*LANES];
  assign good = sync_q[2*LANES-1:LANES]
              & ~sync_q[LANES-1:0];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    state_t        st_q;
    state_t        st_d;
    logic [TW-1:0] tmr_q;
    logic [TW-1:0] tmr_d;
    logic [FW-1:0] flt_q;
    logic [FW-1:0] flt_d;
    logic [7:0]    rty_q;
    logic [7:0]    dwn_q;
    logic          run;
    logic          rty_inc;
    logic          dwn_inc;
    logic          rst_o;
    logic          up_o;

    assign run = lane_enable[i] & clock_ok;

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        st_q  <= ST_RESET;
        tmr_q <= '0;
        flt_q <= '0;
      end else begin
        st_q  <= st_d;
        tmr_q <= tmr_d;
        flt_q <= flt_d;
      end
    end

    // Loss of done outranks timeout, which outranks the lock filter.
    always_comb begin
      st_d    = st_q;
      rty_inc = 1'b0;
      dwn_inc = 1'b0;
      if (!run) begin
        st_d = ST_RESET;
      end else begin
        unique case (st_q)
          ST_RESET: begin
            if (tmr_q == T_RST) st_d = ST_WAIT_DONE;
          end
          ST_WAIT_DONE: begin
            if (done[i]) begin
              st_d = ST_WAIT_LOCK;
            end else if (tmr_q == T_TO) begin
              st_d    = ST_RESET;
              rty_inc = 1'b1;
            end
          end
          ST_WAIT_LOCK: begin
            if (!done[i] || tmr_q == T_TO) begin
              st_d    = ST_RESET;
              rty_inc = 1'b1;
            end else if (good[i] && flt_q == F_LAST) begin
              st_d = ST_UP;
            end
          end
          ST_UP: begin
            if (!done[i]) begin
              st_d    = ST_RESET;
              dwn_inc = 1'b1;
            end else if (!good[i] && flt_q == F_LAST) begin
              st_d    = ST_WAIT_LOCK;
              dwn_inc = 1'b1;
            end
          end
          default: st_d = ST_RESET;
        endcase
      end

      tmr_d = '0;
      flt_d = '0;
      if (st_d == st_q) begin
        unique case (st_q)
          ST_RESET:     tmr_d = run ? tmr_q + 1'b1 : '0;
          ST_WAIT_DONE: tmr_d = tmr_q + 1'b1;
          ST_WAIT_LOCK: begin
            tmr_d = tmr_q + 1'b1;
            flt_d = good[i] ? flt_q + 1'b1 : '0;
          end
          ST_UP:        flt_d = good[i] ? '0 : flt_q + 1'b1;
          default: begin
            tmr_d = '0;
            flt_d = '0;
          end
        endcase
      end
    end

    always_comb begin
      rst_o = (st_q == ST_RESET);
      up_o  = (st_q == ST_UP);
    end

    always_ff @(posedge clock) begin
      if (!reset_n || status_clear) begin
        rty_q <= '0;
        dwn_q <= '0;
      end else begin
        if (rty_inc && rty_q != 8'hFF) rty_q <= rty_q + 8'd1;
        if (dwn_inc && dwn_q != 8'hFF) dwn_q <= dwn_q + 8'd1;
      end
    end

    assign gt_reset_all[i]       = rst_o;
    assign lane_up[i]            = up_o;
    assign lane_state[2*i +: 2]  = st_q;
    assign retry_count[8*i +: 8] = rty_q;
    assign down_count[8*i +: 8]  = dwn_q;
  end

endmodule

// File: tb/tb_eth_link_ctrl.sv
// Scoreboard bench for eth_link_ctrl: expectations are queued with
// their cycle offset when stimulus is applied and checked as they fall due.
module tb_eth_link_ctrl;

  localparam int LANES = 2;

  localparam int S_GTR = 0;
  localparam int S_UP  = 1;
  localparam int S_ST  = 2;
  localparam int S_RTY = 3;
  localparam int S_DWN = 4;

  logic               clock;
  logic               reset_n;
  logic               clock_ok;
  logic [LANES-1:0]   lane_enable;
  logic               status_clear;
  logic [LANES-1:0]   gt_tx_done;
  logic [LANES-1:0]   gt_rx_done;
  logic [LANES-1:0]   rx_block_lock;
  logic [LANES-1:0]   rx_high_ber;
  logic [LANES-1:0]   gt_reset_all;
  logic [LANES-1:0]   lane_up;
  logic [2*LANES-1:0] lane_state;
  logic [8*LANES-1:0] retry_count;
  logic [8*LANES-1:0] down_count;

  typedef struct packed {
    logic [3:0]  sel;
    logic [3:0]  lane;
    logic [15:0] dly;
    logic [31:0] exp;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    n_chk;
  int    n_err;

  eth_link_ctrl #(
    .LANES          (LANES),
    .RESET_CYCLES   (16),
    .TIMEOUT_CYCLES (100),
    .FILTER_CYCLES  (8)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .clock_ok      (clock_ok),
    .lane_enable   (lane_enable),
    .status_clear  (status_clear),
    .gt_tx_done    (gt_tx_done),
    .gt_rx_done    (gt_rx_done),
    .rx_block_lock (rx_block_lock),
    .rx_high_ber   (rx_high_ber),
    .gt_reset_all  (gt_reset_all),
    .lane_up       (lane_up),
    .lane_state    (lane_state),
    .retry_count   (retry_count),
    .down_count    (down_count)
  );

  initial begin
    clock = 1'b0;
    forever #4 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] probe(input logic [3:0] sel,
                                        input logic [3:0] lane);
    int l;
    l = int'(lane);
    case (int'(sel))
      S_GTR:   probe = 32'(gt_reset_all);
      S_UP:    probe = 32'(lane_up);
      S_ST:    probe = 32'(lane_state);
      S_RTY:   probe = 32'(retry_count[l*8 +: 8]);
      S_DWN:   probe = 32'(down_count[l*8 +: 8]);
      default: probe = '0;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_at(input string tag, input int sel,
                           input int lane, input int dly,
                           input logic [31:0] exp);
    exp_t e;
    e.sel  = 4'(sel);
    e.lane = 4'(lane);
    e.dly  = 16'(dly);
    e.exp  = exp;
    sb.push_back(e);
    tags.push_back(tag);
  endtask

  task automatic drain();
    exp_t  e;
    string t;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      t = tags.pop_front();
      if (e.dly != 0) begin
        repeat (int'(e.dly)) @(posedge clock);
        #1;
      end
      check(t, probe(e.sel, e.lane), e.exp);
    end
  endtask

  initial begin
    n_chk         = 0;
    n_err         = 0;
    reset_n       = 1'b0;
    clock_ok      = 1'b1;
    lane_enable   = 2'b11;
    status_clear  = 1'b0;
    gt_tx_done    = 2'b11;
    gt_rx_done    = 2'b11;
    rx_block_lock = 2'b11;
    rx_high_ber   = 2'b00;
    tick(3);

    expect_at("rst_gtr",   S_GTR, 0, 0, 32'h3);
    expect_at("rst_up",    S_UP,  0, 0, 32'h0);
    expect_at("rst_state", S_ST,  0, 0, 32'h0);
    expect_at("rst_rty0",  S_RTY, 0, 0, 32'h0);
    expect_at("rst_dwn1",  S_DWN, 1, 0, 32'h0);
    drain();

    // Clean bring-up of both lanes.
    reset_n = 1'b1;
    expect_at("bu_hold", S_GTR, 0, 15, 32'h3);
    expect_at("bu_drop", S_GTR, 0, 1,  32'h0);
    expect_at("bu_wd",   S_ST,  0, 0,  32'h5);
    expect_at("bu_wl",   S_ST,  0, 1,  32'hA);
    expect_at("bu_pend", S_UP,  0, 7,  32'h0);
    expect_at("bu_up",   S_UP,  0, 1,  32'h3);
    expect_at("bu_rty0", S_RTY, 0, 0,  32'h0);
    expect_at("bu_rty1", S_RTY, 1, 0,  32'h0);
    expect_at("bu_dwn0", S_DWN, 0, 0,  32'h0);
    drain();

    // Short lock glitch on lane 1 is filtered out.
    rx_block_lock[1] = 1'b0;
    tick(5);
    rx_block_lock[1] = 1'b1;
    expect_at("glitch_up",  S_UP,  0, 12, 32'h3);
    expect_at("glitch_dwn", S_DWN, 1, 0,  32'h0);
    drain();

    // Sustained lock loss on lane 1.
    rx_block_lock[1] = 1'b0;
    expect_at("loss_still_up", S_UP,  0, 9, 32'h3);
    expect_at("loss_up",       S_UP,  0, 1, 32'h1);
    expect_at("loss_state",    S_ST,  0, 0, 32'hB);
    expect_at("loss_dwn1",     S_DWN, 1, 0, 32'h1);
    expect_at("loss_dwn0",     S_DWN, 0, 0, 32'h0);
    drain();
    tick(10);
    rx_block_lock[1] = 1'b1;
    expect_at("relock_pend", S_UP,  0, 9, 32'h1);
    expect_at("relock_up",   S_UP,  0, 1, 32'h3);
    expect_at("relock_rty1", S_RTY, 1, 0, 32'h0);
    drain();

    // clock_ok dropped for three cycles.
    clock_ok = 1'b0;
    expect_at("ckok_gtr",  S_GTR, 0, 1, 32'h3);
    expect_at("ckok_up",   S_UP,  0, 0, 32'h0);
    expect_at("ckok_dwn1", S_DWN, 1, 0, 32'h1);
    expect_at("ckok_rty0", S_RTY, 0, 0, 32'h0);
    drain();
    tick(2);
    clock_ok = 1'b1;
    expect_at("ckok_hold",  S_GTR, 0, 15, 32'h3);
    expect_at("ckok_rel",   S_GTR, 0, 1,  32'h0);
    expect_at("ckok_reup",  S_UP,  0, 9,  32'h3);
    expect_at("ckok_dwn_k", S_DWN, 1, 0,  32'h1);
    drain();

    // Mid-run reset, then lane 0 stuck without rx_done.
    gt_rx_done[0] = 1'b0;
    reset_n       = 1'b0;
    tick(1);
    expect_at("mid_rst_dwn1",  S_DWN, 1, 0, 32'h0);
    expect_at("mid_rst_state", S_ST,  0, 0, 32'h0);
    expect_at("mid_rst_gtr",   S_GTR, 0, 0, 32'h3);
    drain();
    reset_n = 1'b1;
    expect_at("l1_up",        S_UP,  0, 25, 32'h2);
    expect_at("to_pre",       S_RTY, 0, 90, 32'h0);
    expect_at("to_pre_state", S_ST,  0, 0,  32'hD);
    expect_at("to_inc",       S_RTY, 0, 1,  32'h1);
    expect_at("to_gtr",       S_GTR, 0, 0,  32'h1);
    expect_at("rst_again",    S_ST,  0, 16, 32'hD);
    expect_at("to2_pre",      S_RTY, 0, 99, 32'h1);
    expect_at("to2",          S_RTY, 0, 1,  32'h2);
    expect_at("l1_dwn",       S_DWN, 1, 0,  32'h0);
    drain();

    // 300 retries saturate; status_clear beats a same-cycle increment.
    expect_at("sat",      S_RTY, 0, 34800 - 232, 32'hFF);
    expect_at("sat_dwn0", S_DWN, 0, 0,           32'h0);
    drain();
    status_clear = 1'b1;
    expect_at("clr", S_RTY, 0, 1, 32'h0);
    drain();
    status_clear = 1'b0;
    tick(114);
    status_clear = 1'b1;
    expect_at("clr_win", S_RTY, 0, 1, 32'h0);
    expect_at("clr_fsm", S_ST,  0, 0, 32'hC);
    drain();
    status_clear = 1'b0;
    expect_at("inc_after", S_RTY, 0, 116, 32'h1);
    expect_at("up_kept",   S_UP,  0, 0,   32'h2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
